// File: rtl/fire_pkg.sv
// Shared Fire-code constants, mode encodings, channel payload type and burst-mask helper.
package fire_pkg;

  localparam int unsigned N      = 64;
  localparam int unsigned K      = 40;
  localparam int unsigned B      = 8;
  localparam int unsigned SHW    = 7;
  localparam int unsigned CW     = 16;
  localparam int unsigned LFSR_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    ENCODE = 3'b001,
    DECODE = 3'b010
  } fire_mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps at bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic [N-1:0] data;
    logic [N-1:0] mask;
  } chan_word_t;

  // Shifts past the top of the codeword fall off; shift >= N yields zero
  function automatic logic [N-1:0] burst_mask(input logic [B-1:0]   pattern,
                                              input logic [SHW-1:0] shift);
    return N'(pattern) << shift;
  endfunction

endpackage

// File: rtl/fire_chan_lfsr.sv
// 16-bit Fibonacci LFSR that advances once per step and resets to the package seed.
module fire_chan_lfsr
  import fire_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (step) begin
      state <= {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/fire_burst_channel.sv
// Burst-error channel stage: XORs a shifted burst mask into each accepted codeword.
// Optional FIRE_CHAN_LFSR_EN sources pattern/shift from an internal LFSR when cfg_rand=1.
module fire_burst_channel
  import fire_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic           cfg_enable,
  input  logic [B-1:0]   cfg_pattern,
  input  logic [SHW-1:0] cfg_shift,
  input  logic           cfg_rand,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic [N-1:0]   out_mask,
  output logic [CW-1:0]  frame_cnt,
  output logic [CW-1:0]  err_cnt
);

  chan_state_e    state;
  chan_state_e    state_next;
  logic           accept;
  logic           emit;
  logic [B-1:0]   pattern_sel;
  logic [SHW-1:0] shift_sel;
  logic [N-1:0]   mask;
  chan_word_t     word_q;

  assign in_ready = (state == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = (state == FULL) && out_ready;

`ifdef FIRE_CHAN_LFSR_EN
  logic [LFSR_W-1:0] lfsr;
  logic [SHW-1:0]    lfsr_shift;
  logic [1:0]        unused_lfsr_hi;

  fire_chan_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (accept),
    .state (lfsr)
  );

  assign lfsr_shift     = SHW'(lfsr[13:8]);
  assign unused_lfsr_hi = lfsr[15:14];

  // Clamp keeps the whole random burst inside the codeword
  always_comb begin
    pattern_sel = cfg_pattern;
    shift_sel   = cfg_shift;
    if (cfg_rand) begin
      pattern_sel = lfsr[B-1:0] | B'(1);
      shift_sel   = (lfsr_shift > SHW'(N - B)) ? SHW'(N - B) : lfsr_shift;
    end
  end
`else
  logic unused_rand;

  assign unused_rand = cfg_rand;

  always_comb begin
    pattern_sel = cfg_pattern;
    shift_sel   = cfg_shift;
  end
`endif

  assign mask = cfg_enable ? burst_mask(pattern_sel, shift_sel) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (emit && !accept) state_next = EMPTY;
    endcase
  end

  // Payload only loads on accept, so it holds through backpressure and after drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (accept) begin
      word_q.data <= in_data ^ mask;
      word_q.mask <= mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (accept) begin
      if (frame_cnt != '1) frame_cnt <= frame_cnt + CW'(1);
      if ((mask != '0) && (err_cnt != '1)) err_cnt <= err_cnt + CW'(1);
    end
  end

  assign out_valid = (state == FULL);
  assign out_data  = word_q.data;
  assign out_mask  = word_q.mask;

endmodule

// File: tb/tb_fire_burst_channel.sv
// Self-checking bench for fire_burst_channel with a behavioural mask/LFSR reference model.
module tb_fire_burst_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        cfg_enable;
  logic [7:0]  cfg_pattern;
  logic [6:0]  cfg_shift;
  logic        cfg_rand;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [63:0] out_mask;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;
  int exp_errs   = 0;

  fire_burst_channel dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .cfg_enable  (cfg_enable),
    .cfg_pattern (cfg_pattern),
    .cfg_shift   (cfg_shift),
    .cfg_rand    (cfg_rand),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_mask    (out_mask),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference mask: set bit shift+i for each pattern bit i that still lands inside 64 bits
  function automatic logic [63:0] ref_mask(input logic en, input logic [7:0] p, input int sh);
    logic [63:0] m;
    m = '0;
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (p[i] && (sh + i) < 64) m[sh + i] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_enable = 1'b0; cfg_pattern = '0;
    cfg_shift = '0; cfg_rand = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_checks++; if (out_mask !== 64'h0) begin n_fail++; $display("FAIL reset_mask: got %h expected 0", out_mask); end
    n_checks++; if (frame_cnt !== 16'h0 || err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", frame_cnt, err_cnt); end
    rst = 1'b0;
    exp_frames = 0; exp_errs = 0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [63:0] d;
    d = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; cfg_pattern = 8'b1011_0001; cfg_shift = 7'd10;
    cfg_enable = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_frames++; exp_errs++;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_mask !== 64'h2C400) begin n_fail++; $display("FAIL basic_mask: got %h expected %h", out_mask, 64'h2C400); end
    n_checks++; if (out_data !== (d ^ 64'h2C400)) begin n_fail++; $display("FAIL basic_data: got %h expected %h", out_data, d ^ 64'h2C400); end
    n_checks++; if (frame_cnt !== 16'(exp_frames) || err_cnt !== 16'(exp_errs)) begin n_fail++; $display("FAIL basic_cnt: got %0d/%0d expected %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_truncate();
    @(negedge clk);
    in_valid = 1'b1; in_data = '0; cfg_pattern = 8'hFF; cfg_shift = 7'd60; cfg_enable = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    cfg_shift = 7'd64;
    exp_frames++; exp_errs++;
    n_checks++; if (out_mask !== 64'hF000_0000_0000_0000) begin n_fail++; $display("FAIL trunc_mask60: got %h expected %h", out_mask, 64'hF000_0000_0000_0000); end
    @(negedge clk);
    in_valid = 1'b0;
    exp_frames++;
    n_checks++; if (out_mask !== 64'h0 || out_data !== 64'h0) begin n_fail++; $display("FAIL trunc_mask64: got %h/%h expected 0/0", out_mask, out_data); end
    n_checks++; if (err_cnt !== 16'(exp_errs) || frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL trunc_cnt: got %0d/%0d expected %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs); end
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    logic [63:0] prev;
    prev = '0;
    cfg_enable = 1'b0; cfg_pattern = 8'hFF; cfg_shift = 7'd0; out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pass_ready[%0d]: got %b expected 1", i, in_ready); end
      if (i > 0) begin
        n_checks++; if (out_data !== prev || out_mask !== 64'h0) begin n_fail++; $display("FAIL pass_data[%0d]: got %h/%h expected %h/0", i, out_data, out_mask, prev); end
      end
      if (i < 5) begin
        in_valid = 1'b1; in_data = {$urandom, $urandom}; prev = in_data; exp_frames++;
      end else begin
        in_valid = 1'b0;
      end
    end
    n_checks++; if (frame_cnt !== 16'(exp_frames) || err_cnt !== 16'(exp_errs)) begin n_fail++; $display("FAIL pass_cnt: got %0d/%0d expected %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs); end
  endtask

  task automatic test_backpressure();
    logic [63:0] da, db, ma, mb;
    da = 64'hDEAD_BEEF_0000_1111; db = 64'h5555_AAAA_1234_5678;
    @(negedge clk);
    in_valid = 1'b1; in_data = da; cfg_enable = 1'b1; cfg_pattern = 8'h3C; cfg_shift = 7'd20; out_ready = 1'b0;
    ma = ref_mask(1'b1, 8'h3C, 20);
    exp_frames++; exp_errs++;
    @(negedge clk);
    in_data = db;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hs[%0d]: got valid %b ready %b expected 1/0", i, out_valid, in_ready); end
      n_checks++; if (out_data !== (da ^ ma) || out_mask !== ma) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h/%h expected %h/%h", i, out_data, out_mask, da ^ ma, ma); end
      cfg_pattern = 8'($urandom); cfg_shift = 7'($urandom_range(0, 63));
      @(negedge clk);
    end
    cfg_pattern = 8'h81; cfg_shift = 7'd5; out_ready = 1'b1;
    mb = ref_mask(1'b1, 8'h81, 5);
    exp_frames++; exp_errs++;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== (db ^ mb) || out_mask !== mb) begin n_fail++; $display("FAIL bp_second: got %b %h/%h expected 1 %h/%h", out_valid, out_data, out_mask, db ^ mb, mb); end
    n_checks++; if (frame_cnt !== 16'(exp_frames) || err_cnt !== 16'(exp_errs)) begin n_fail++; $display("FAIL bp_cnt: got %0d/%0d expected %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || out_data !== (db ^ mb)) begin n_fail++; $display("FAIL bp_drain: got %b %h expected 0 %h", out_valid, out_data, db ^ mb); end
  endtask

  task automatic test_random();
    logic [127:0] q[$];
    logic [127:0] e;
    logic [63:0]  m;
    logic         acc, emt;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 2) != 0);
      in_data = {$urandom, $urandom}; cfg_pattern = 8'($urandom);
      cfg_shift = 7'($urandom_range(0, 127)); cfg_enable = ($urandom_range(0, 4) != 0); cfg_rand = 1'b0;
      #1;
      n_checks++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, out_valid, q.size() != 0); end
      n_checks++; if (in_ready !== (q.size() == 0 || out_ready)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, in_ready, q.size() == 0 || out_ready); end
      acc = in_valid && (q.size() == 0 || out_ready);
      emt = (q.size() != 0) && out_ready;
      if (q.size() != 0) begin
        e = q[0];
        n_checks++; if (out_data !== e[127:64] || out_mask !== e[63:0]) begin n_fail++; $display("FAIL rnd_word[%0d]: got %h/%h expected %h/%h", c, out_data, out_mask, e[127:64], e[63:0]); end
      end
      if (emt) void'(q.pop_front());
      if (acc) begin
        m = ref_mask(cfg_enable, cfg_pattern, int'(cfg_shift));
        q.push_back({in_data ^ m, m});
        exp_frames++;
        if (m != 0) exp_errs++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (frame_cnt !== 16'(exp_frames) || err_cnt !== 16'(exp_errs)) begin n_fail++; $display("FAIL rnd_cnt: got %0d/%0d expected %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'hFFFF_0000_FFFF_0000; cfg_enable = 1'b1; cfg_pattern = 8'h01;
    cfg_shift = 7'd0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    n_checks++; if (frame_cnt !== 16'h0 || err_cnt !== 16'h0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d/%0d expected 0/0", frame_cnt, err_cnt); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    exp_frames = 0; exp_errs = 0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin n_fail++; $display("FAIL rstmid_after: got %b %h expected 0 0", out_valid, out_data); end
  endtask

`ifdef FIRE_CHAN_LFSR_EN
  // Reference LFSR steps from the polynomial exponents 16,14,13,11
  task automatic test_lfsr();
    logic [15:0] l;
    logic [63:0] prev_m;
    logic [7:0]  p;
    int          sh, prev_sh;
    logic        fb;
    l = 16'hACE1; prev_m = '0; prev_sh = 0;
    for (int f = 0; f <= 1000; f++) begin
      @(negedge clk);
      if (f > 0) begin
        n_checks++; if (out_mask !== prev_m) begin n_fail++; $display("FAIL lfsr_mask[%0d]: got %h expected %h", f - 1, out_mask, prev_m); end
        n_checks++; if (out_mask == 64'h0 || out_mask[prev_sh] !== 1'b1 || (out_mask >> prev_sh) > 64'hFF) begin n_fail++; $display("FAIL lfsr_shape[%0d]: got %h shift %0d", f - 1, out_mask, prev_sh); end
      end
      if (f == 1) begin
        n_checks++; if (out_mask !== (64'hE1 << 44)) begin n_fail++; $display("FAIL lfsr_first: got %h expected %h", out_mask, 64'hE1 << 44); end
      end
      if (f < 1000) begin
        in_valid = 1'b1; cfg_rand = 1'b1; cfg_enable = 1'b1; out_ready = 1'b1;
        in_data = {$urandom, $urandom}; cfg_pattern = 8'($urandom); cfg_shift = 7'($urandom);
        p = l[7:0] | 8'h01;
        sh = int'(l[13:8]);
        if (sh > 56) sh = 56;
        prev_m = ref_mask(1'b1, p, sh); prev_sh = sh;
        fb = l[16 - 16] ^ l[16 - 14] ^ l[16 - 13] ^ l[16 - 11];
        l = {fb, l[15:1]};
      end else begin
        in_valid = 1'b0; cfg_rand = 1'b0;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_truncate();
    test_passthrough();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef FIRE_CHAN_LFSR_EN
    test_lfsr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
